ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
// - Upstream of the menu/game FSM. Turns the PS/2 set-2 byte stream from the PS/2 receiver into held-key
//   flags key[5:0] and the last make code keycode[7:0], both consumed by the menu FSM and game logic.
// - Handles E0 (extended), F0 (break) and E1 (Pause) prefixes, an inter-byte timeout and keyboard reset/overrun codes.
// PARAMETERS
// - TIMEOUT_CYCLES  6_500_000  max pclk cycles between prefix and next byte (~100 ms @ 65 MHz); >=2
// PORTS
// - pclk       in   1  pixel clock; all logic on rising edge
// - rst_n      in   1  asynchronous, active-low reset
// - rx_data    in   8  byte from PS/2 receiver, valid only when rx_valid=1
// - rx_valid   in   1  one-cycle strobe per received byte
// - rx_err     in   1  one-cycle strobe on parity/frame error (byte discarded)
// - key        out  6  held flags: [0]UP [1]DOWN [2]LEFT [3]RIGHT [4]ENTER [5]ESC
// - keycode    out  8  last make code without prefix; 0 when no make is held
// - key_press  out  1  one-cycle pulse when any key[] bit goes 0->1
// BEHAVIOUR
// - Reset: key=0, keycode=0, key_press=0, state=IDLE, timer=0, skip counter=0.
// - Map (set 2): E0 75 UP, E0 72 DOWN, E0 6B LEFT, E0 74 RIGHT, 5A or E0 5A ENTER, 76 ESC.
// - Latency: outputs registered; update on the cycle after the rx_valid carrying the final byte.
// - States:
//   IDLE: E0->EXT; F0->BRK; E1->PSKIP (cnt=7); AA/FC/00/FF->clear key,keycode (stay IDLE);
//         other byte b = make: set mapped bit (non-extended map), keycode<=b.
//   EXT: F0->EXT_BRK; other b = extended make: set mapped bit (extended map), keycode<=b, ->IDLE.
//   BRK: b = break: clear mapped bit (non-extended map); if b==keycode then keycode<=0; ->IDLE.
//   EXT_BRK: as BRK with extended map, ->IDLE.
//   PSKIP: each rx_valid decrements cnt; byte ignored; cnt==1 on strobe ->IDLE.
// - Unmapped codes only affect keycode (make sets it, matching break clears it).
// - Typematic repeats of a held make: keycode rewritten, key unchanged, no key_press.
// - key_press = |(key_nxt & ~key), registered with key.
// - Timer: counts in EXT/BRK/EXT_BRK/PSKIP while rx_valid=0, cleared on every rx_valid and in IDLE;
//   reaching TIMEOUT_CYCLES-1 -> IDLE; pending byte dropped, key/keycode unchanged.
// - rx_err: state->IDLE, timer and skip cnt cleared, key/keycode unchanged; wins over rx_valid same cycle.
// - rx_valid with state change on the timeout cycle: byte is processed, timeout ignored.
// - Several key bits may be held together; key is not forced one-hot.
// - rst_n low mid-sequence: immediate return to reset values; no partial prefix survives.
// CONFIGURATION
// - WASD_ALIAS_EN defined: non-extended 1D->UP, 1B->DOWN, 1C->LEFT, 23->RIGHT, same make/break rules,
//   OR-ed with arrow keys (bit clears only when its last source is released; track sources separately).
// - Undefined: 1D/1B/1C/23 are unmapped (keycode only).
// TESTING
// - Reset: rst_n=0 mid-EXT -> key=0, keycode=0, key_press=0; next byte 5A treated as plain ENTER make.
// - Bytes E0,75 -> cycle after 75: key=6'b000001, keycode=8'h75, key_press=1 for 1 cycle;
//   then E0,F0,75 -> key=0, keycode=0.
// - 5A,5A,5A (typematic) -> key[4]=1 after first, key_press only once; F0,5A -> key=0, keycode=0.
// - E0 then no byte for TIMEOUT_CYCLES -> state IDLE; following 74 -> keycode=74, key=0 (non-extended 74 unmapped).
// - E1,14,77,E1,F0,14,F0,77 -> no key/keycode change; next 76 -> key[5]=1. Byte AA while held -> key=0.
// - With WASD_ALIAS_EN: 1D, E0 75, F0 1D -> key[0] stays 1; E0 F0 75 -> key[0]=0. Without: 1D -> key=0, keycode=1D.

Source files
------------

// File: rtl/ps2_rx_if.sv
// ps2_rx_if: byte stream from the PS/2 receiver (master) to the key decoder (slave); rx_data, rx_valid strobe, rx_err strobe
interface ps2_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  modport master (output rx_data, rx_valid, rx_err);
  modport slave  (input  rx_data, rx_valid, rx_err);
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 bytes -> held key flags, last make code, press pulse
// Ports: pclk, rst_n (async active-low), rx (ps2_rx_if.slave), key[5:0] UP/DOWN/LEFT/RIGHT/ENTER/ESC,
//        keycode (last held make, 0 when none), key_press (pulse on any key bit 0->1).
// Define WASD_ALIAS_EN to alias 1D/1B/1C/23 onto UP/DOWN/LEFT/RIGHT as an independent source.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 6_500_000
) (
  input  logic       pclk,
  input  logic       rst_n,
  ps2_rx_if.slave    rx,
  output logic [5:0] key,
  output logic [7:0] keycode,
  output logic       key_press
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PSKIP} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [5:0] held, held_nxt, key_nxt, hit;
  logic [7:0] d, keycode_nxt;
  logic v, ext, prefix, rst_code, mk, brk, timeout;
  assign d        = rx.rx_data;
  assign v        = rx.rx_valid & ~rx.rx_err;
  assign ext      = state == EXT || state == EXT_BRK;
  assign prefix   = d == 8'hE0 || d == 8'hF0 || d == 8'hE1;
  assign rst_code = v && state == IDLE && (d == 8'hAA || d == 8'hFC || d == 8'h00 || d == 8'hFF);
  assign mk       = v && ((state == IDLE && !prefix && !rst_code) || (state == EXT && d != 8'hF0));
  assign brk      = v && (state == BRK || state == EXT_BRK);
  // a byte arriving on the expiry cycle takes priority over the timeout
  assign timeout  = state != IDLE && !rx.rx_valid && timer == TW'(TIMEOUT_CYCLES - 1);
  assign hit = ext ? (d == 8'h75 ? 6'b000001 : d == 8'h72 ? 6'b000010 : d == 8'h6B ? 6'b000100 :
                      d == 8'h74 ? 6'b001000 : d == 8'h5A ? 6'b010000 : 6'b000000)
                   : (d == 8'h5A ? 6'b010000 : d == 8'h76 ? 6'b100000 : 6'b000000);
`ifdef WASD_ALIAS_EN
  // WASD aliases are held separately so an arrow release does not drop a still-held letter key
  logic [3:0] wasd, wasd_nxt, whit;
  assign whit = ext ? 4'b0000 : d == 8'h1D ? 4'b0001 : d == 8'h1B ? 4'b0010 :
                d == 8'h1C ? 4'b0100 : d == 8'h23 ? 4'b1000 : 4'b0000;
  assign wasd_nxt = rst_code ? 4'b0000 : brk ? wasd & ~whit : mk ? wasd | whit : wasd;
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) wasd <= '0;
    else wasd <= wasd_nxt;
  assign key     = held | {2'b00, wasd};
  assign key_nxt = held_nxt | {2'b00, wasd_nxt};
`else
  assign key     = held;
  assign key_nxt = held_nxt;
`endif
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      cnt       <= '0;
      held      <= '0;
      keycode   <= '0;
      key_press <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      cnt       <= cnt_nxt;
      held      <= held_nxt;
      keycode   <= keycode_nxt;
      key_press <= |(key_nxt & ~key);
    end
  always_comb begin
    state_nxt = state;
    if (rx.rx_err) state_nxt = IDLE;
    else if (rx.rx_valid)
      case (state)
        IDLE:    state_nxt = d == 8'hE0 ? EXT : d == 8'hF0 ? BRK : d == 8'hE1 ? PSKIP : IDLE;
        EXT:     state_nxt = d == 8'hF0 ? EXT_BRK : IDLE;
        PSKIP:   state_nxt = cnt == 3'd1 ? IDLE : PSKIP;
        default: state_nxt = IDLE;
      endcase
    else if (timeout) state_nxt = IDLE;
  end
  always_comb begin
    held_nxt    = rst_code ? 6'b0 : brk ? held & ~hit : mk ? held | hit : held;
    keycode_nxt = rst_code ? 8'h00 : mk ? d : (brk && d == keycode) ? 8'h00 : keycode;
    cnt_nxt     = (rx.rx_err || timeout) ? 3'd0 : (v && state == IDLE && d == 8'hE1) ? 3'd7 :
                  (v && state == PSKIP) ? cnt - 3'd1 : cnt;
    timer_nxt   = (rx.rx_valid || rx.rx_err || state == IDLE || timeout) ? '0 : timer + 1'b1;
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed table, corner sequences and random bytes checked against a message-level model
module tb_ps2_key_decoder;
  localparam int T = 16;
  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       e;
    logic [5:0] k;
    logic [7:0] c;
    logic       p;
  } vec_t;
  logic pclk = 1'b0, rst_n = 1'b0;
  logic [5:0] key;
  logic [7:0] keycode;
  logic key_press;
  int checks = 0, fails = 0;
  ps2_rx_if rx();
  ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .pclk(pclk), .rst_n(rst_n), .rx(rx), .key(key), .keycode(keycode), .key_press(key_press)
  );
  always #5 pclk = ~pclk;

  // Model: collect bytes into a message (prefixes + final byte), then apply it whole.
  logic [7:0] q[$];
  int idle;
  logic [5:0] m_arrow;
  logic [3:0] m_wasd;
  logic [7:0] m_code;
  logic m_press;

  function automatic logic [5:0] std_bit(input logic is_ext, input logic [7:0] b);
    if (is_ext)
      case (b)
        8'h75: return 6'd1;
        8'h72: return 6'd2;
        8'h6B: return 6'd4;
        8'h74: return 6'd8;
        8'h5A: return 6'd16;
        default: return 6'd0;
      endcase
    case (b)
      8'h5A: return 6'd16;
      8'h76: return 6'd32;
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [3:0] alias_bit(input logic is_ext, input logic [7:0] b);
`ifdef WASD_ALIAS_EN
    if (!is_ext)
      case (b)
        8'h1D: return 4'd1;
        8'h1B: return 4'd2;
        8'h1C: return 4'd4;
        8'h23: return 4'd8;
        default: return 4'd0;
      endcase
`endif
    return 4'd0;
  endfunction

  function automatic logic [5:0] m_key();
    return m_arrow | {2'b00, m_wasd};
  endfunction

  task automatic model_reset();
    q.delete();
    idle = 0;
    m_arrow = '0;
    m_wasd = '0;
    m_code = '0;
    m_press = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] d, input logic v, input logic e);
    logic [5:0] old, sb;
    logic [3:0] wb;
    logic is_ext, is_brk;
    old = m_key();
    if (e) begin
      q.delete();
      idle = 0;
    end else if (v) begin
      idle = 0;
      q.push_back(d);
      if (q[0] == 8'hE1) begin
        if (q.size() == 8) q.delete();
      end else if (q.size() == 1 && d inside {8'hAA, 8'hFC, 8'h00, 8'hFF}) begin
        m_arrow = '0;
        m_wasd = '0;
        m_code = '0;
        q.delete();
      end else if ((q.size() == 1 && d inside {8'hE0, 8'hF0}) || (q.size() == 2 && q[0] == 8'hE0 && d == 8'hF0)) begin
      end else begin
        is_ext = q[0] == 8'hE0;
        is_brk = q[0] == 8'hF0 || q.size() == 3;
        sb = std_bit(is_ext, d);
        wb = alias_bit(is_ext, d);
        if (is_brk) begin
          m_arrow &= ~sb;
          m_wasd &= ~wb;
          if (d == m_code) m_code = 8'h00;
        end else begin
          m_arrow |= sb;
          m_wasd |= wb;
          m_code = d;
        end
        q.delete();
      end
    end else if (q.size() > 0) begin
      idle++;
      if (idle == T) begin
        q.delete();
        idle = 0;
      end
    end
    m_press = |(m_key() & ~old);
  endtask

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got key=%b keycode=%h key_press=%b, expected key=%b keycode=%h key_press=%b",
               name, act[14:9], act[8:1], act[0], exp[14:9], exp[8:1], exp[0]);
    end
  endtask

  task automatic step(input logic [7:0] d, input logic v, input logic e);
    rx.rx_data = d;
    rx.rx_valid = v;
    rx.rx_err = e;
    @(posedge pclk);
    #1;
    rx.rx_valid = 1'b0;
    rx.rx_err = 1'b0;
  endtask

  task automatic rnd_cycle(input logic [7:0] d, input logic v, input logic e);
    model_step(d, v, e);
    step(d, v, e);
    chk("random", {key, keycode, key_press}, {m_key(), m_code, m_press});
  endtask

  initial begin
    vec_t tbl[$];
    logic [7:0] pool [16];
    int r, n;
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A,
             8'h76, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hAA, 8'h14, 8'h33};
    rx.rx_data = 8'h00;
    rx.rx_valid = 1'b0;
    rx.rx_err = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk("reset", {key, keycode, key_press}, 15'd0);
    rst_n = 1'b1;

    tbl.push_back('{8'hE0, 1'b1, 1'b0, 6'b000000, 8'h00, 1'b0});
    tbl.push_back('{8'h75, 1'b1, 1'b0, 6'b000001, 8'h75, 1'b1});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 6'b000001, 8'h75, 1'b0});
    tbl.push_back('{8'hE0, 1'b1, 1'b0, 6'b000001, 8'h75, 1'b0});
    tbl.push_back('{8'hF0, 1'b1, 1'b0, 6'b000001, 8'h75, 1'b0});
    tbl.push_back('{8'h75, 1'b1, 1'b0, 6'b000000, 8'h00, 1'b0});
    tbl.push_back('{8'h5A, 1'b1, 1'b0, 6'b010000, 8'h5A, 1'b1});
    tbl.push_back('{8'h5A, 1'b1, 1'b0, 6'b010000, 8'h5A, 1'b0});
    tbl.push_back('{8'h5A, 1'b1, 1'b0, 6'b010000, 8'h5A, 1'b0});
    tbl.push_back('{8'hF0, 1'b1, 1'b0, 6'b010000, 8'h5A, 1'b0});
    tbl.push_back('{8'h5A, 1'b1, 1'b0, 6'b000000, 8'h00, 1'b0});
    tbl.push_back('{8'hE1, 1'b1, 1'b0, 6'b000000, 8'h00, 1'b0});
    tbl.push_back('{8'h14, 1'b1, 1'b0, 6'b000000, 8'h00, 1'b0});
    tbl.push_back('{8'h77, 1'b1, 1'b0, 6'b000000, 8'h00, 1'b0});
    tbl.push_back('{8'hE1, 1'b1, 1'b0, 6'b000000, 8'h00, 1'b0});
    tbl.push_back('{8'hF0, 1'b1, 1'b0, 6'b000000, 8'h00, 1'b0});
    tbl.push_back('{8'h14, 1'b1, 1'b0, 6'b000000, 8'h00, 1'b0});
    tbl.push_back('{8'hF0, 1'b1, 1'b0, 6'b000000, 8'h00, 1'b0});
    tbl.push_back('{8'h77, 1'b1, 1'b0, 6'b000000, 8'h00, 1'b0});
    tbl.push_back('{8'h76, 1'b1, 1'b0, 6'b100000, 8'h76, 1'b1});
    tbl.push_back('{8'hE0, 1'b1, 1'b0, 6'b100000, 8'h76, 1'b0});
    tbl.push_back('{8'h72, 1'b1, 1'b0, 6'b100010, 8'h72, 1'b1});
    tbl.push_back('{8'hF0, 1'b1, 1'b0, 6'b100010, 8'h72, 1'b0});
    tbl.push_back('{8'h76, 1'b1, 1'b0, 6'b000010, 8'h72, 1'b0});
    tbl.push_back('{8'hE0, 1'b1, 1'b0, 6'b000010, 8'h72, 1'b0});
    tbl.push_back('{8'h74, 1'b1, 1'b1, 6'b000010, 8'h72, 1'b0});
    tbl.push_back('{8'h74, 1'b1, 1'b0, 6'b000010, 8'h74, 1'b0});
    tbl.push_back('{8'hAA, 1'b1, 1'b0, 6'b000000, 8'h00, 1'b0});
    tbl.push_back('{8'h76, 1'b1, 1'b0, 6'b100000, 8'h76, 1'b1});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, 6'b000000, 8'h00, 1'b0});
    foreach (tbl[i]) begin
      step(tbl[i].d, tbl[i].v, tbl[i].e);
      chk($sformatf("vec%0d", i), {key, keycode, key_press}, {tbl[i].k, tbl[i].c, tbl[i].p});
    end

    step(8'h76, 1'b1, 1'b0);
    step(8'hE0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("reset_mid_ext", {key, keycode, key_press}, 15'd0);
    @(negedge pclk);
    rst_n = 1'b1;
    step(8'h5A, 1'b1, 1'b0);
    chk("enter_after_reset", {key, keycode, key_press}, {6'b010000, 8'h5A, 1'b1});
    step(8'hF0, 1'b1, 1'b0);
    step(8'h5A, 1'b1, 1'b0);
    chk("enter_release", {key, keycode, key_press}, 15'd0);

    step(8'hE0, 1'b1, 1'b0);
    repeat (T - 1) step(8'h00, 1'b0, 1'b0);
    step(8'h74, 1'b1, 1'b0);
    chk("byte_at_expiry", {key, keycode, key_press}, {6'b001000, 8'h74, 1'b1});
    step(8'hE0, 1'b1, 1'b0);
    step(8'hF0, 1'b1, 1'b0);
    step(8'h74, 1'b1, 1'b0);
    chk("right_release", {key, keycode, key_press}, 15'd0);
    step(8'hE0, 1'b1, 1'b0);
    repeat (T) step(8'h00, 1'b0, 1'b0);
    step(8'h74, 1'b1, 1'b0);
    chk("after_timeout", {key, keycode, key_press}, {6'b000000, 8'h74, 1'b0});

`ifdef WASD_ALIAS_EN
    step(8'h1D, 1'b1, 1'b0);
    chk("wasd_make", {key, keycode, key_press}, {6'b000001, 8'h1D, 1'b1});
    step(8'hE0, 1'b1, 1'b0);
    step(8'h75, 1'b1, 1'b0);
    step(8'hF0, 1'b1, 1'b0);
    step(8'h1D, 1'b1, 1'b0);
    chk("wasd_release_arrow_held", {key, keycode, key_press}, {6'b000001, 8'h75, 1'b0});
    step(8'hE0, 1'b1, 1'b0);
    step(8'hF0, 1'b1, 1'b0);
    step(8'h75, 1'b1, 1'b0);
    chk("arrow_release_last", {key, keycode, key_press}, 15'd0);
`else
    step(8'h1D, 1'b1, 1'b0);
    chk("1d_unmapped", {key, keycode, key_press}, {6'b000000, 8'h1D, 1'b0});
`endif

    rst_n = 1'b0;
    #2;
    @(negedge pclk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        n = T - 1 + $urandom_range(0, 2);
        repeat (n) rnd_cycle(8'h00, 1'b0, 1'b0);
      end else if (r < 5) rnd_cycle(pool[$urandom_range(0, 15)], 1'($urandom_range(0, 1)), 1'b1);
      else if (r < 60) rnd_cycle(pool[$urandom_range(0, 15)], 1'b1, 1'b0);
      else rnd_cycle(pool[$urandom_range(0, 15)], 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
